// File: rtl/audio_deshifter.sv
// audio_deshifter
// Serial-to-parallel receiver for the codec ADC path. The codec bit clock,
// LR clock and serial data are brought into the system clock domain with
// 2-FF synchronizers, bit-clock rising edges are detected with a third
// stage, and MSB-first words are assembled into left/right samples.
// A completed right-channel word strobes valid; a word whose bit count is
// not WIDTH strobes frame_err.
module audio_deshifter #(
  parameter int WIDTH     = 16,
  parameter int I2S_DELAY = 0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             exchan,
  input  logic             aud_bclk,
  input  logic             aud_adclrck,
  input  logic             aud_adcdat,
  output logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             frame_err
);

  // Counter must reach WIDTH+1 so over-long words remain distinguishable.
  localparam int             CW      = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  C_WIDTH = CW'(WIDTH);
  localparam logic [CW-1:0]  C_MAX   = CW'(WIDTH + 1);

  // Synchronizer and edge-detect stages
  logic             r_bclk_s1;
  logic             r_bclk_s2;
  logic             r_bclk_d;
  logic             r_lrck_s1;
  logic             r_lrck_s2;
  logic             r_dat_s1;
  logic             r_dat_s2;

  // Word assembly state
  logic             r_lrck_prev;
  logic             r_started;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  // Registered outputs
  logic [WIDTH-1:0] r_ldata;
  logic [WIDTH-1:0] r_rdata;
  logic             r_valid;
  logic             r_ferr;

  // Combinational next-state terms
  logic             w_rise;
  logic             w_boundary;
  logic             w_commit;
  logic             w_chan_right;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  // Bring the three codec pins into the clk domain and delay bclk once more for edge detection.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_d  <= 1'b0;
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_dat_s1  <= 1'b0;
      r_dat_s2  <= 1'b0;
    end else begin
      r_bclk_s1 <= aud_bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_lrck_s1 <= aud_adclrck;
      r_lrck_s2 <= r_lrck_s1;
      r_dat_s1  <= aud_adcdat;
      r_dat_s2  <= r_dat_s1;
    end
  end

  // Edge, boundary and commit decode; the committed word belongs to the channel that just ended.
  always_comb begin
    w_rise       = r_bclk_s2 & ~r_bclk_d;
    w_boundary   = w_rise & (r_lrck_s2 != r_lrck_prev);
    w_commit     = w_boundary & r_started;
    w_chan_right = r_lrck_prev ^ exchan;
  end

  // Next shift-register and bit-counter values; a boundary restarts the word.
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    if (w_boundary) begin
      w_shift_nxt = '0;
      if (I2S_DELAY == 0) begin
        // Boundary bit is the MSB of the new word.
        w_shift_nxt[WIDTH-1] = r_dat_s2;
        w_cnt_nxt            = CW'(1);
      end else begin
        // Boundary bit is the previous word's tail in I2S framing; drop it.
        w_cnt_nxt = '0;
      end
    end else if (w_rise) begin
      // Bit k lands at WIDTH-1-k; counts at or beyond WIDTH match no position.
      for (int i = 0; i < WIDTH; i++) begin
        w_shift_nxt[i] = (r_cnt == CW'(WIDTH - 1 - i)) ? r_dat_s2 : r_shift[i];
      end
      if (r_cnt < C_MAX) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
    end
  end

  // Word assembly state: updates only on bclk rise cycles.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_lrck_prev <= 1'b0;
      r_started   <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
    end else begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_rise) begin
        r_lrck_prev <= r_lrck_s2;
      end
      if (w_boundary) begin
        r_started <= 1'b1;
      end
    end
  end

  // Commit the finished word to its channel register and raise the one-cycle strobes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ldata <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_commit & w_chan_right;
      r_ferr  <= w_commit & (r_cnt != C_WIDTH);
      if (w_commit && !w_chan_right) begin
        r_ldata <= r_shift;
      end
      if (w_commit && w_chan_right) begin
        r_rdata <= r_shift;
      end
    end
  end

  assign ldata     = r_ldata;
  assign rdata     = r_rdata;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

endmodule
